// File: rtl/inst_loader_pkg.sv
// Shared types and SRAM port layout for the instruction loader and the BNN controller.
// The controller's ctrl_sram bus uses the same bit positions as sram_ctrl.
package inst_loader_pkg;

    localparam int INST_ADDR_W  = 11;
    localparam int INST_DATA_W  = 16;
    localparam int SRAM_CEN_BIT = INST_ADDR_W;
    localparam int SRAM_WEN_BIT = INST_ADDR_W + 1;
    localparam int SRAM_CTRL_W  = INST_ADDR_W + 2;

    // WEN=1, CEN=1, address 0: no SRAM access this cycle.
    localparam logic [SRAM_CTRL_W-1:0] SRAM_IDLE = {1'b1, 1'b1, {INST_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RESTART,
        S_RUN,
        S_DONE
    } state_t;

    // Write request for one word at addr (both strobes active-low).
    function automatic logic [SRAM_CTRL_W-1:0] sram_write(input logic [INST_ADDR_W-1:0] addr);
        return {1'b0, 1'b0, addr};
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Boot/program sequencer: streams host words into the instruction SRAM while the
// controller is held in reset, then runs the controller until it fetches past the program.
import inst_loader_pkg::*;

module inst_loader #(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_valid,
    input  logic [INST_DATA_W-1:0] host_data,
    input  logic                   host_last,
    output logic                   host_ready,
    input  logic                   start,
    input  logic                   pause_in,
    input  logic [ADDR_W+1:0]      ctrl_sram,
    output logic [ADDR_W+1:0]      sram_ctrl,
    output logic [INST_DATA_W-1:0] sram_din,
    output logic                   ctrl_rst,
    output logic                   ctrl_pause,
    output logic                   done,
    output logic                   ovf
);

    // The SRAM bit layout lives in the package, so the geometry is fixed there.
    if (ADDR_W != INST_ADDR_W || DEPTH != (1 << ADDR_W)) begin : g_bad_geometry
        $error("inst_loader: ADDR_W/DEPTH disagree with inst_loader_pkg SRAM layout");
    end

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     prog_len;
    logic [ADDR_W+1:0]   sram_q;
    logic                hold_pause;

    logic                accept;
    logic                fresh;
    logic [ADDR_W-1:0]   wr_addr;
    logic                at_end;
    logic                closing;
    logic                hit_end;

    assign accept  = host_valid & host_ready;
    // Any accept outside LOAD opens a new program at address 0.
    assign fresh   = (state != S_LOAD);
    assign wr_addr = fresh ? '0 : wr_ptr;
    assign at_end  = (wr_addr == ADDR_W'(DEPTH - 1));
    assign closing = host_last | at_end;
    // prog_len == DEPTH has its MSB set, so a full program can never match.
    assign hit_end = ~ctrl_sram[SRAM_CEN_BIT] && ({1'b0, ctrl_sram[ADDR_W-1:0]} == prog_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            prog_len   <= '0;
            sram_q     <= SRAM_IDLE;
            sram_din   <= '0;
            host_ready <= 1'b1;
            ctrl_rst   <= 1'b1;
            hold_pause <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            // NOTE: later non-blocking assignments in the same block override this default.
            sram_q <= SRAM_IDLE;
            if (accept) begin
                sram_q     <= sram_write(wr_addr);
                sram_din   <= host_data;
                wr_ptr     <= wr_addr + ADDR_W'(1);
                host_ready <= 1'b1;
                ctrl_rst   <= 1'b1;
                hold_pause <= 1'b0;
                done       <= 1'b0;
                if (fresh)
                    ovf <= 1'b0;
                if (closing) begin
                    state    <= S_READY;
                    prog_len <= {1'b0, wr_addr} + (ADDR_W + 1)'(1);
                    if (!host_last)
                        ovf <= 1'b1;
                end else begin
                    state <= S_LOAD;
                end
            end else begin
                unique case (state)
                    S_READY: begin
                        if (start) begin
                            state      <= S_RUN;
                            host_ready <= 1'b0;
                            ctrl_rst   <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (start) begin
                            state      <= S_RESTART;
                            host_ready <= 1'b0;
                            ctrl_rst   <= 1'b1;
                            hold_pause <= 1'b0;
                            done       <= 1'b0;
                        end
                    end
                    S_RESTART: begin
                        state    <= S_RUN;
                        ctrl_rst <= 1'b0;
                    end
                    S_RUN: begin
                        if (hit_end) begin
                            state      <= S_DONE;
                            host_ready <= 1'b1;
                            hold_pause <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The controller owns the SRAM port with zero added latency while running.
    assign sram_ctrl  = (state == S_RUN) ? ctrl_sram : sram_q;
    assign ctrl_pause = hold_pause | ((state == S_RUN) & pause_in);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: phase-level reference model, emulated SRAM,
// and a randomized fake controller that fetches sequentially with gaps and pauses.
module tb_inst_loader;

    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int CW    = AW + 2;
    localparam logic [CW-1:0] IDLE_CTRL = {2'b11, 11'd0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_valid = 1'b0;
    logic [15:0]   host_data = '0;
    logic          host_last = 1'b0;
    logic          host_ready;
    logic          start = 1'b0;
    logic          pause_in = 1'b0;
    logic [CW-1:0] ctrl_sram = IDLE_CTRL;
    logic [CW-1:0] sram_ctrl;
    logic [15:0]   sram_din;
    logic          ctrl_rst;
    logic          ctrl_pause;
    logic          done;
    logic          ovf;

    inst_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .start      (start),
        .pause_in   (pause_in),
        .ctrl_sram  (ctrl_sram),
        .sram_ctrl  (sram_ctrl),
        .sram_din   (sram_din),
        .ctrl_rst   (ctrl_rst),
        .ctrl_pause (ctrl_pause),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (program phases, not RTL states) ----------------
    typedef enum {M_EMPTY, M_FILLING, M_LOADED, M_RELOAD, M_EXEC, M_FINISHED} phase_t;

    phase_t      m_phase = M_EMPTY;
    int          m_next = 0;
    int          m_len = 0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    bit          m_wr = 0;
    int          m_wr_addr = 0;
    logic [15:0] m_wr_data = '0;
    bit          model_on = 0;

    function automatic bit m_ready();
        return !(m_phase inside {M_RELOAD, M_EXEC});
    endfunction

    always @(posedge clk) begin : model
        int a;
        if (rst) begin
            m_phase  <= M_EMPTY;
            m_next   <= 0;
            m_len    <= 0;
            m_done   <= 0;
            m_ovf    <= 0;
            m_wr     <= 0;
            model_on <= 1;
        end else begin
            m_wr <= 0;
            if (host_valid && m_ready()) begin
                a = (m_phase == M_FILLING) ? m_next : 0;
                m_wr      <= 1;
                m_wr_addr <= a;
                m_wr_data <= host_data;
                m_next    <= a + 1;
                m_done    <= 0;
                if (m_phase != M_FILLING) m_ovf <= 0;
                if (host_last || a == DEPTH - 1) begin
                    m_len   <= a + 1;
                    m_phase <= M_LOADED;
                    if (!host_last) m_ovf <= 1;
                end else begin
                    m_phase <= M_FILLING;
                end
            end else begin
                case (m_phase)
                    M_LOADED:   if (start) m_phase <= M_EXEC;
                    M_FINISHED: if (start) begin m_phase <= M_RELOAD; m_done <= 0; end
                    M_RELOAD:   m_phase <= M_EXEC;
                    M_EXEC: begin
                        if (ctrl_sram[AW] == 1'b0 && int'(ctrl_sram[AW-1:0]) == m_len) begin
                            m_phase <= M_FINISHED;
                            m_done  <= 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [CW-1:0] es;
        if (model_on) begin
            check("host_ready", host_ready, m_ready());
            check("ctrl_rst", ctrl_rst, m_phase inside {M_EMPTY, M_FILLING, M_LOADED, M_RELOAD});
            check("ctrl_pause", ctrl_pause,
                  (m_phase == M_FINISHED) || (m_phase == M_EXEC && pause_in));
            check("done", done, m_done);
            check("ovf", ovf, m_ovf);
            if (m_phase == M_EXEC) es = ctrl_sram;
            else if (m_wr)         es = {2'b00, AW'(m_wr_addr)};
            else                   es = IDLE_CTRL;
            check("sram_ctrl", sram_ctrl, es);
            if (m_wr) check("sram_din", sram_din, m_wr_data);
        end
    end

    // ---------------- emulated instruction SRAM ----------------
    logic [15:0] mem [DEPTH];
    int          wr_count = 0;

    always @(posedge clk) begin
        if (sram_ctrl[AW] == 1'b0 && sram_ctrl[AW+1] == 1'b0) begin
            mem[sram_ctrl[AW-1:0]] <= sram_din;
            wr_count <= wr_count + 1;
        end
    end

    // ---------------- fake controller: sequential fetch with random gaps/pauses ----------------
    logic [AW-1:0] pc = '0;
    int            last_issue = -1;

    always @(posedge clk) begin
        #1;
        pause_in = ($urandom_range(0, 4) == 0);
        if (ctrl_rst !== 1'b0) pc = '0;
        if (ctrl_rst !== 1'b0 || done || pause_in || $urandom_range(0, 3) == 0) begin
            ctrl_sram = {2'b11, pc};
        end else begin
            ctrl_sram  = {2'b10, pc};
            last_issue = int'(pc);
            pc         = pc + 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] w [DEPTH];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int b;
        b = 20;
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        while (host_ready !== 1'b1 && b > 0) begin
            step();
            b--;
        end
        if (host_ready !== 1'b1) check("send_ready", host_ready, 1);
        step();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = budget;
        while (done !== 1'b1 && b > 0) begin
            step();
            b--;
        end
        check("done_reached", done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int base;
        logic [15:0] d;

        step();
        step();
        @(negedge clk);
        check("rst_host_ready", host_ready, 1);
        check("rst_ctrl_rst", ctrl_rst, 1);
        check("rst_ctrl_pause", ctrl_pause, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sram_ctrl", sram_ctrl, 32'h1800);
        check("rst_sram_din", sram_din, 0);
        step();
        rst = 1'b0;

        // 5-word program, then run to completion at address 5
        base = wr_count;
        for (int i = 0; i < 5; i++) begin
            w[i] = 16'($urandom);
            send(w[i], i == 4);
        end
        step();
        check("p5_writes", wr_count - base, 5);
        for (int i = 0; i < 5; i++) check("p5_mem", mem[i], w[i]);
        pulse_start();
        @(negedge clk);
        check("start_latency", ctrl_rst, 0);
        wait_done(400);
        @(negedge clk);
        check("p5_end_addr", last_issue, 5);
        check("p5_pause", ctrl_pause, 1);

        // restart from DONE: one cycle of controller reset, same end address
        pulse_start();
        @(negedge clk);
        check("restart_rst", ctrl_rst, 1);
        check("restart_done", done, 0);
        step();
        @(negedge clk);
        check("restart_run", ctrl_rst, 0);
        wait_done(400);
        @(negedge clk);
        check("rerun_end_addr", last_issue, 5);

        // gapped host stream, 9 words
        base = wr_count;
        for (int i = 0; i < 9; i++) begin
            w[i] = 16'($urandom);
            send(w[i], i == 8);
            step();
        end
        check("gap_writes", wr_count - base, 9);
        for (int i = 0; i < 9; i++) check("gap_mem", mem[i], w[i]);
        pulse_start();
        wait_done(600);
        @(negedge clk);
        check("gap_end_addr", last_issue, 9);

        // accept + start together in DONE: the accept wins
        d = 16'($urandom);
        host_valid = 1'b1;
        host_last  = 1'b1;
        host_data  = d;
        start      = 1'b1;
        step();
        host_valid = 1'b0;
        host_last  = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check("acc_wins_sram", sram_ctrl, 32'h0000);
        check("acc_wins_din", sram_din, d);
        check("acc_wins_rst", ctrl_rst, 1);
        check("acc_wins_done", done, 0);
        step();
        @(negedge clk);
        check("acc_no_restart", ctrl_rst, 1);
        pulse_start();
        wait_done(200);
        @(negedge clk);
        check("one_word_end", last_issue, 1);

        // reset in the middle of a load; start is then ignored
        for (int i = 0; i < 3; i++) send(16'($urandom), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", host_ready, 1);
        check("midrst_ctrl_rst", ctrl_rst, 1);
        check("midrst_sram", sram_ctrl, 32'h1800);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("idle_ignores_start", ctrl_rst, 1);
        end
        start = 1'b0;

        // 2049 words without last: truncation at DEPTH, then a new program
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = 16'($urandom);
            send(w[i], 1'b0);
        end
        @(negedge clk);
        check("ovf_set", ovf, 1);
        check("ovf_ready", host_ready, 1);
        d = 16'($urandom);
        send(d, 1'b0);
        @(negedge clk);
        check("ovf_cleared", ovf, 0);
        check("ovf_new_addr", sram_ctrl, 32'h0000);
        check("ovf_new_din", sram_din, d);
        step();
        check("ovf_mem0", mem[0], d);
        check("ovf_mem1", mem[1], w[1]);
        check("ovf_mem_top", mem[DEPTH-1], w[DEPTH-1]);
        d = 16'($urandom);
        send(d, 1'b1);
        step();
        check("ovf_mem1_new", mem[1], d);
        pulse_start();
        wait_done(200);
        @(negedge clk);
        check("two_word_end", last_issue, 2);

        // full-depth program never completes
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(16'($urandom), i == DEPTH - 1);
        @(negedge clk);
        check("full_no_ovf", ovf, 0);
        pulse_start();
        repeat (2200) step();
        @(negedge clk);
        check("full_never_done", done, 0);
        check("full_running", ctrl_rst, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
